rr_chan_mux: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and the output. It is the successor to the single-bit 2:1 data-flow mux: selection is either fixed (external select, as before) or automatic round-robin across requesting channels. Each selected word is captured into a single output register stage with backpressure. It sits between several streaming producers and one shared downstream consumer.

---
 rtl/rr_chan_mux_pkg.sv | 8 +
 rtl/rr_chan_mux_if.sv | 29 ++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/rr_chan_mux.sv | 100 ++++++++++
 tb/tb_rr_chan_mux.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_chan_mux_pkg.sv
// Shared definitions for the round-robin channel mux.
// Mode encodings used by the top-level grant selector.
package rr_chan_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_chan_mux_if.sv
// Handshake bundle between N streaming producers, the mux and
// the shared downstream consumer.
interface rr_chan_mux_if #(
  parameter int W = 8,
  parameter int N = 4
);
  localparam int SW = $clog2(N);

  logic          mode;
  logic [SW-1:0] sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_ch;
  logic          out_valid;
  logic          out_ready;

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: first requester at or
// after ptr, wrapping at N-1 (N need not be a power of two).
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_valid
);

  localparam logic [SW:0] NL = (SW+1)'(N);

  logic [SW:0]   pos;
  logic [SW-1:0] idx;

  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    pos       = '0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (SW+1)'(k);
      if (pos >= NL) pos = pos - NL;
      idx = pos[SW-1:0];
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < N; i++)
      gnt[i] = gnt_valid && (gnt_idx == SW'(i));
  end

endmodule

// File: rtl/rr_chan_mux.sv
// N-channel registered stream mux, fixed-select or round-robin,
// with a single backpressured output register.
module rr_chan_mux
  import rr_chan_mux_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 4
) (
  input logic        clk,
  input logic        rst,
  rr_chan_mux_if.slave bus
);

  localparam int SW = $clog2(N);

  logic [SW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  data_q, data_d;
  logic [SW-1:0] ch_q, ch_d;
  logic          valid_q, valid_d;

  logic [N-1:0]  rr_gnt, fx_gnt, gnt;
  logic [SW-1:0] rr_idx, g_idx;
  logic          rr_valid, fx_valid, g_valid;
  logic          load_en, xfer;
  logic [W-1:0]  g_data;

  rr_arbiter #(.N(N)) u_arb (
    .req       (bus.in_valid),
    .ptr       (ptr_q),
    .gnt       (rr_gnt),
    .gnt_idx   (rr_idx),
    .gnt_valid (rr_valid)
  );

  // An out-of-range sel matches no channel, so it never grants.
  always_comb begin
    fx_gnt = '0;
    for (int i = 0; i < N; i++)
      fx_gnt[i] = bus.in_valid[i] && (bus.sel == SW'(i));
  end

  assign fx_valid = |fx_gnt;
  assign load_en  = !valid_q || bus.out_ready;

  always_comb begin
    if (bus.mode == MODE_RR) begin
      gnt     = rr_gnt;
      g_idx   = rr_idx;
      g_valid = rr_valid;
    end else begin
      gnt     = fx_gnt;
      g_idx   = bus.sel;
      g_valid = fx_valid;
    end
  end

  assign xfer         = !rst && load_en && g_valid;
  assign bus.in_ready = xfer ? gnt : '0;

  always_comb begin
    g_data = '0;
    for (int i = 0; i < N; i++)
      if (g_idx == SW'(i)) g_data = bus.in_data[i*W +: W];
  end

  always_comb begin
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (load_en) begin
      valid_d = g_valid;
      if (g_valid) begin
        data_d = g_data;
        ch_d   = g_idx;
        if (bus.mode == MODE_RR)
          ptr_d = (g_idx == SW'(N-1)) ? '0 : g_idx + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_rr_chan_mux.sv
// Bench for rr_chan_mux: N=4/W=8 and N=3/W=4 instances against a
// cycle-level reference model of the grant and output register.
module tb_rr_chan_mux;

  logic clk = 1'b0;
  logic rst4, rst3;

  always #5 clk = ~clk;

  rr_chan_mux_if #(.W(8), .N(4)) a ();
  rr_chan_mux_if #(.W(4), .N(3)) b ();

  rr_chan_mux #(.W(8), .N(4)) u4 (
    .clk (clk),
    .rst (rst4),
    .bus (a)
  );

  rr_chan_mux #(.W(4), .N(3)) u3 (
    .clk (clk),
    .rst (rst3),
    .bus (b)
  );

  typedef struct {
    logic [31:0] iro, ire;
    logic [31:0] ovo, ove;
    logic [31:0] dout, de;
    logic [31:0] cho, che;
  } res_t;

  int vectors     = 0;
  int miscompares = 0;

  int m_ptr [2];
  int m_ov  [2];
  int m_od  [2];
  int m_ch  [2];

  // One clock of stimulus on DUT id (0: N=4, 1: N=3) plus model.
  task automatic step(input int id, input bit r, input bit md,
                      input int s, input int v,
                      input logic [31:0] d, input bit ordy,
                      output res_t o);
    int n, w, g;
    bit ld;
    n = (id == 0) ? 4 : 3;
    w = (id == 0) ? 8 : 4;
    if (id == 0) begin
      rst4 = r; a.mode = md; a.sel = 2'(s);
      a.in_valid = 4'(v); a.in_data = d;
      a.out_ready = ordy;
    end else begin
      rst3 = r; b.mode = md; b.sel = 2'(s);
      b.in_valid = 3'(v); b.in_data = d[11:0];
      b.out_ready = ordy;
    end
    g  = -1;
    ld = !r && (m_ov[id] == 0 || ordy);
    if (ld) begin
      if (!md) begin
        if (s < n && v[s]) g = s;
      end else begin
        for (int k = 0; k < n; k++) begin
          int j;
          j = (m_ptr[id] + k) % n;
          if (g < 0 && v[j]) g = j;
        end
      end
    end
    o.ire = (g < 0) ? 0 : (1 << g);
    @(negedge clk);
    o.iro = '0;
    if (id == 0) o.iro[3:0] = a.in_ready;
    else         o.iro[2:0] = b.in_ready;
    @(posedge clk);
    #1;
    if (r) begin
      m_ptr[id] = 0; m_ov[id] = 0;
      m_od[id]  = 0; m_ch[id] = 0;
    end else if (ld) begin
      if (g >= 0) begin
        m_ov[id] = 1;
        m_od[id] = int'((d >> (g * w)) & ((32'd1 << w) - 1));
        m_ch[id] = g;
        if (md) m_ptr[id] = (g + 1) % n;
      end else begin
        m_ov[id] = 0;
      end
    end
    o.ove = m_ov[id];
    o.de  = m_od[id];
    o.che = m_ch[id];
    o.ovo = '0; o.dout = '0; o.cho = '0;
    if (id == 0) begin
      o.ovo[0] = a.out_valid;
      o.dout[7:0] = a.out_data;
      o.cho[1:0] = a.out_ch;
    end else begin
      o.ovo[0] = b.out_valid;
      o.dout[3:0] = b.out_data;
      o.cho[1:0] = b.out_ch;
    end
  endtask

  function automatic bit model_diff(res_t r);
    return (r.iro !== r.ire) || (r.ovo !== r.ove) ||
           (r.ove[0] && ((r.dout !== r.de) || (r.cho !== r.che)));
  endfunction

  function automatic string fmt(res_t r);
    return $sformatf("got rdy=%h ov=%h data=%h ch=%h need rdy=%h ov=%h data=%h ch=%h",
      r.iro, r.ovo, r.dout, r.cho, r.ire, r.ove, r.de, r.che);
  endfunction

  task automatic test_reset();
    res_t r;
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 1, 0, 15, $urandom(), 0, r);
      vectors++;
      if (r.iro !== 0 || r.ovo !== 0 || r.dout !== 0 || r.cho !== 0) begin
        miscompares++;
        $display("FAIL reset: got rdy=%h ov=%h data=%h ch=%h need all 0",
                 r.iro, r.ovo, r.dout, r.cho);
      end
    end
    step(0, 0, 1, 0, 15, $urandom(), 1, r);
    vectors++;
    if (r.ovo !== 1 || r.cho !== 0 || model_diff(r)) begin
      miscompares++;
      $display("FAIL reset_first_ch0: %s", fmt(r));
    end
  endtask

  task automatic test_fixed();
    res_t r;
    logic [31:0] d;
    d = $urandom();
    d[23:16] = 8'hA5;
    step(0, 0, 0, 2, 15, d, 1, r);
    vectors++;
    if (r.iro !== 32'h4 || r.dout !== 32'hA5 || r.cho !== 2 || model_diff(r)) begin
      miscompares++;
      $display("FAIL fixed_sel2: %s", fmt(r));
    end
    step(0, 0, 0, 3, 7, $urandom(), 1, r);
    vectors++;
    if (r.iro !== 0 || r.ovo !== 0 || model_diff(r)) begin
      miscompares++;
      $display("FAIL fixed_sel3_idle: %s", fmt(r));
    end
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, $urandom_range(0, 3), $urandom_range(0, 15),
           $urandom(), bit'($urandom_range(0, 1)), r);
      vectors++;
      if (model_diff(r)) begin
        miscompares++;
        $display("FAIL fixed_rand: %s", fmt(r));
      end
    end
  endtask

  task automatic test_rr_fair();
    res_t r;
    step(0, 1, 1, 0, 15, $urandom(), 1, r);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 0, 15, $urandom(), 1, r);
      vectors++;
      if (r.ovo !== 1 || r.cho !== 32'(i % 4) || model_diff(r)) begin
        miscompares++;
        $display("FAIL rr_fair[%0d]: %s", i, fmt(r));
      end
    end
  endtask

  task automatic test_skip_wrap();
    res_t r;
    int exp_ch [7] = '{1, 3, 1, 3, 2, 0, 1};
    int vld    [7] = '{10, 10, 10, 10, 4, 1, 15};
    step(0, 1, 1, 0, 0, $urandom(), 1, r);
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 1, 0, vld[i], $urandom(), 1, r);
      vectors++;
      if (r.ovo !== 1 || r.cho !== 32'(exp_ch[i]) || model_diff(r)) begin
        miscompares++;
        $display("FAIL rr_skip_wrap[%0d]: %s", i, fmt(r));
      end
    end
  endtask

  task automatic test_backpressure();
    res_t r;
    logic [31:0] held;
    step(0, 1, 1, 0, 0, $urandom(), 1, r);
    step(0, 0, 1, 0, 15, $urandom(), 1, r);
    held = r.dout;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, $urandom_range(0, 3), 15, $urandom(), 0, r);
      vectors++;
      if (r.iro !== 0 || r.ovo !== 1 || r.dout !== held ||
          r.cho !== 0 || model_diff(r)) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: %s held=%h", i, fmt(r), held);
      end
    end
    step(0, 0, 1, 0, 15, $urandom(), 1, r);
    vectors++;
    if (r.iro !== 32'h2 || r.ovo !== 1 || r.cho !== 1 || model_diff(r)) begin
      miscompares++;
      $display("FAIL bp_release: %s", fmt(r));
    end
  endtask

  task automatic test_back_to_back();
    res_t r;
    for (int i = 0; i < 300; i++) begin
      step(0, ($urandom_range(0, 39) == 0), bit'($urandom_range(0, 1)),
           $urandom_range(0, 3), $urandom_range(0, 15), $urandom(),
           ($urandom_range(0, 3) != 0), r);
      vectors++;
      if (model_diff(r)) begin
        miscompares++;
        $display("FAIL b2b_rand[%0d]: %s", i, fmt(r));
      end
    end
  endtask

  task automatic test_npot();
    res_t r;
    rst4 = 1'b1;
    step(1, 1, 0, 0, 7, $urandom(), 1, r);
    step(1, 0, 0, 3, 7, $urandom(), 1, r);
    vectors++;
    if (r.iro !== 0 || r.ovo !== 0 || model_diff(r)) begin
      miscompares++;
      $display("FAIL npot_sel3: %s", fmt(r));
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 0, 7, $urandom(), 1, r);
      vectors++;
      if (r.ovo !== 1 || r.cho !== 32'(i % 3) || model_diff(r)) begin
        miscompares++;
        $display("FAIL npot_rr[%0d]: %s", i, fmt(r));
      end
    end
    for (int i = 0; i < 150; i++) begin
      step(1, ($urandom_range(0, 39) == 0), bit'($urandom_range(0, 1)),
           $urandom_range(0, 3), $urandom_range(0, 7), $urandom(),
           ($urandom_range(0, 3) != 0), r);
      vectors++;
      if (model_diff(r)) begin
        miscompares++;
        $display("FAIL npot_rand[%0d]: %s", i, fmt(r));
      end
    end
  endtask

  initial begin
    rst4 = 1'b1;
    rst3 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_ptr[i] = 0; m_ov[i] = 0; m_od[i] = 0; m_ch[i] = 0;
    end
    test_reset();
    test_fixed();
    test_rr_fair();
    test_skip_wrap();
    test_backpressure();
    test_back_to_back();
    test_npot();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
